iir_out_stage: RTL

- Output conditioning stage directly downstream of the fourth IIR section.
- Consumes the 12-bit signed filtered sample every clock (one sample per clock, 2 kHz).
- Applies final gain with rounding, then saturates to the DAC word width.
- Gates output validity during the post-reset filter transient and reports per-window peak magnitude and a clip-event count.

---
 rtl/iir_pkg.sv | 11 +
 rtl/iir_round_sat.sv | 35 +++
 rtl/iir_out_stage.sv | 127 ++++++++++++
 3 files changed

// File: rtl/iir_pkg.sv
// Shared widths and sample types for the IIR output conditioning stage.
package iir_pkg;

  localparam int unsigned IIR_IN_W  = 12;
  localparam int unsigned IIR_OUT_W = 10;
  localparam int unsigned SAT_CNT_W = 16;

  typedef logic signed [IIR_IN_W-1:0]  sample_in_t;
  typedef logic signed [IIR_OUT_W-1:0] sample_out_t;

endpackage

// File: rtl/iir_round_sat.sv
// Combinational round-half-up, arithmetic shift and clip to the output width.
module iir_round_sat #(
  parameter int unsigned PW    = 21,
  parameter int unsigned OUT_W = 10,
  parameter int unsigned SHIFT = 7
) (
  input  logic signed [PW-1:0]    i_p,
  output logic signed [OUT_W-1:0] o_y,
  output logic                    o_sat
);

  // One guard bit so adding the rounding constant can never wrap.
  localparam logic signed [PW:0] RND   = (PW+1)'(1 << (SHIFT - 1));
  localparam logic signed [PW:0] Y_MAX = (PW+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [PW:0] Y_MIN = ~Y_MAX;

  logic signed [PW:0] w_sum;
  logic signed [PW:0] w_r;

  // Round, shift, then clamp into the signed output range.
  always_comb begin
    w_sum = $signed({i_p[PW-1], i_p}) + RND;
    w_r   = w_sum >>> SHIFT;
    o_y   = w_r[OUT_W-1:0];
    o_sat = 1'b0;
    if (w_r > Y_MAX) begin
      o_y   = Y_MAX[OUT_W-1:0];
      o_sat = 1'b1;
    end else if (w_r < Y_MIN) begin
      o_y   = Y_MIN[OUT_W-1:0];
      o_sat = 1'b1;
    end
  end

endmodule

// File: rtl/iir_out_stage.sv
// Output stage after the fourth IIR section: gain, round, saturate, settle
// gating, windowed peak magnitude and clip-event counter.
module iir_out_stage
  import iir_pkg::*;
#(
  parameter int unsigned IN_W       = IIR_IN_W,
  parameter int unsigned OUT_W      = IIR_OUT_W,
  parameter int unsigned GAIN       = 160,
  parameter int unsigned GAIN_SHIFT = 7,
  parameter int unsigned SETTLE     = 16,
  parameter int unsigned WIN_LEN    = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  Xin,
  input  logic                    sat_clr,
  output logic signed [OUT_W-1:0] Yout,
  output logic                    Yvalid,
  output logic                    Ysat,
  output logic [OUT_W-1:0]        Peak,
  output logic                    peak_stb,
  output logic [SAT_CNT_W-1:0]    SatCnt
);

  localparam int unsigned PW    = IN_W + 9;
  localparam int unsigned SW    = $clog2(SETTLE + 1);
  localparam int unsigned WW    = $clog2(WIN_LEN);
  localparam logic signed [8:0] GAIN_S = 9'(GAIN);

  logic signed [PW-1:0]    r_p;
  logic signed [OUT_W-1:0] r_yout;
  logic                    r_ysat;
  logic [SW-1:0]           r_settle;
  logic                    r_valid;
  logic [WW-1:0]           r_win;
  logic [OUT_W-1:0]        r_run;
  logic [OUT_W-1:0]        r_peak;
  logic                    r_stb;
  logic [SAT_CNT_W-1:0]    r_satcnt;

  logic signed [OUT_W-1:0] w_y;
  logic                    w_sat;
  logic [OUT_W-1:0]        w_yu;
  logic [OUT_W-1:0]        w_mag;
  logic [OUT_W-1:0]        w_max;

  iir_round_sat #(
    .PW    (PW),
    .OUT_W (OUT_W),
    .SHIFT (GAIN_SHIFT)
  ) u_round_sat (
    .i_p   (r_p),
    .o_y   (w_y),
    .o_sat (w_sat)
  );

  // Two-stage datapath: full-width product, then rounded/clipped sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p    <= '0;
      r_yout <= '0;
      r_ysat <= 1'b0;
    end else begin
      r_p    <= PW'(Xin) * PW'(GAIN_S);
      r_yout <= w_y;
      r_ysat <= w_sat;
    end
  end

  // Settle counter saturates at SETTLE; validity latches on the SETTLE-th edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_settle <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (r_settle != SW'(SETTLE)) r_settle <= r_settle + SW'(1);
      if (r_settle == SW'(SETTLE - 1)) r_valid <= 1'b1;
    end
  end

  // Magnitude as unsigned: the most negative code maps onto 2^(OUT_W-1).
  always_comb begin
    w_yu  = $unsigned(r_yout);
    w_mag = r_yout[OUT_W-1] ? (~w_yu + OUT_W'(1)) : w_yu;
    w_max = (w_mag > r_run) ? w_mag : r_run;
  end

  // Peak tracking over WIN_LEN valid samples, publishing on the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win  <= '0;
      r_run  <= '0;
      r_peak <= '0;
      r_stb  <= 1'b0;
    end else begin
      r_stb <= 1'b0;
      if (r_valid) begin
        if (r_win == WW'(WIN_LEN - 1)) begin
          r_peak <= w_max;
          r_stb  <= 1'b1;
          r_run  <= '0;
          r_win  <= '0;
        end else begin
          r_run <= w_max;
          r_win <= r_win + WW'(1);
        end
      end
    end
  end

  // Clip counter: clear beats a coincident clip, holds at all-ones.
  always_ff @(posedge clk) begin
    if (rst || sat_clr) begin
      r_satcnt <= '0;
    end else if (r_valid && r_ysat && (r_satcnt != '1)) begin
      r_satcnt <= r_satcnt + SAT_CNT_W'(1);
    end
  end

  assign Yout     = r_yout;
  assign Ysat     = r_ysat;
  assign Yvalid   = r_valid;
  assign Peak     = r_peak;
  assign peak_stb = r_stb;
  assign SatCnt   = r_satcnt;

endmodule
